// File: rtl/entry_alloc_ctrl.sv
// rtl/entry_alloc_ctrl.sv - round-robin allocator and flush sequencer for a valid-bit vector
// Drives one single-bit write per cycle into the valid storage and reads back its full vector.
module entry_alloc_ctrl #(
  parameter int ADDR_LEN = 2,
  parameter int DATA_LEN = 2 ** ADDR_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_req,
  output logic                alloc_gnt,
  output logic [ADDR_LEN-1:0] alloc_addr,
  input  logic                free_valid,
  input  logic [ADDR_LEN-1:0] free_addr,
  input  logic                flush,
  output logic                flush_busy,
  input  logic [DATA_LEN-1:0] valid_vec,
  output logic                wen,
  output logic [ADDR_LEN-1:0] waddr,
  output logic                wdata,
  output logic                full,
  output logic                empty,
  output logic                free_err
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t              state;
  logic [ADDR_LEN-1:0] rr_ptr;
  logic [ADDR_LEN-1:0] flush_cnt;
  logic                found;
  logic [ADDR_LEN-1:0] idx;
  logic [ADDR_LEN-1:0] cand;

  assign full  = &valid_vec;
  assign empty = ~|valid_vec;

  // Walk offsets from farthest to nearest so the entry closest to rr_ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = DATA_LEN - 1; k >= 0; k--) begin
      cand = rr_ptr + k[ADDR_LEN-1:0];
      if (!valid_vec[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

  always_comb begin
    alloc_gnt  = 1'b0;
    alloc_addr = '0;
    wen        = 1'b0;
    waddr      = '0;
    wdata      = 1'b0;
    flush_busy = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (flush) begin
            wen = 1'b0;
          end else if (free_valid) begin
            wen   = 1'b1;
            waddr = free_addr;
          end else if (alloc_req && !full && found) begin
            alloc_gnt  = 1'b1;
            alloc_addr = idx;
            wen        = 1'b1;
            waddr      = idx;
            wdata      = 1'b1;
          end
        end
        FLUSH: begin
          flush_busy = 1'b1;
          wen        = 1'b1;
          waddr      = flush_cnt;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      flush_cnt <= '0;
      free_err  <= 1'b0;
    end else begin
      free_err <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            state     <= FLUSH;
            flush_cnt <= '0;
          end else if (free_valid) begin
            free_err <= ~valid_vec[free_addr];
          end else if (alloc_gnt) begin
            rr_ptr <= idx + 1'b1;
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + 1'b1;
          if (flush_cnt == ADDR_LEN'(DATA_LEN - 1)) begin
            state  <= IDLE;
            rr_ptr <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_entry_alloc_ctrl.sv
// tb/tb_entry_alloc_ctrl.sv - directed self-checking bench for entry_alloc_ctrl
module tb_entry_alloc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alloc_req;
  logic       alloc_gnt;
  logic [1:0] alloc_addr;
  logic       free_valid;
  logic [1:0] free_addr;
  logic       flush;
  logic       flush_busy;
  logic [3:0] vec;
  logic       wen;
  logic [1:0] waddr;
  logic       wdata;
  logic       full;
  logic       empty;
  logic       free_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  entry_alloc_ctrl #(.ADDR_LEN(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc_req  (alloc_req),
    .alloc_gnt  (alloc_gnt),
    .alloc_addr (alloc_addr),
    .free_valid (free_valid),
    .free_addr  (free_addr),
    .flush      (flush),
    .flush_busy (flush_busy),
    .valid_vec  (vec),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .full       (full),
    .empty      (empty),
    .free_err   (free_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Latch the write seen at the negedge, then apply it to the storage model after the edge.
  task automatic adv();
    logic       c_wen;
    logic [1:0] c_waddr;
    logic       c_wdata;
    c_wen   = wen;
    c_waddr = waddr;
    c_wdata = wdata;
    @(posedge clk);
    #1;
    if (c_wen) vec[c_waddr] = c_wdata;
  endtask

  initial begin
    rst_n = 1'b0; alloc_req = 1'b1; free_valid = 1'b0; free_addr = 2'd0;
    flush = 1'b0; vec = 4'b0000;
    @(negedge clk);
    check("rst_wen", wen, 0);
    check("rst_gnt", alloc_gnt, 0);
    check("rst_busy", flush_busy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ferr", free_err, 0);
    adv();

    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("seq_gnt", alloc_gnt, 1);
      check("seq_addr", alloc_addr, i);
      check("seq_wdata", wdata, 1);
      adv();
    end
    @(negedge clk);
    check("full_gnt", alloc_gnt, 0);
    check("full_flag", full, 1);
    check("full_wen", wen, 0);
    adv();

    rst_n = 1'b0; alloc_req = 1'b0;
    adv();
    rst_n = 1'b1; alloc_req = 1'b1; vec = 4'b1011;
    @(negedge clk);
    check("rr_addr2", alloc_addr, 2);
    check("rr_wdata", wdata, 1);
    adv();
    vec = 4'b1001;
    @(negedge clk);
    check("rr_wrap_addr", alloc_addr, 1);
    check("rr_wrap_gnt", alloc_gnt, 1);
    adv();

    vec = 4'b0111; free_valid = 1'b1; free_addr = 2'd2;
    @(negedge clk);
    check("pri_wen", wen, 1);
    check("pri_waddr", waddr, 2);
    check("pri_wdata", wdata, 0);
    check("pri_gnt", alloc_gnt, 0);
    adv();
    free_valid = 1'b0;
    @(negedge clk);
    check("pri_vec", vec, 4'b0011);
    check("pri_ferr", free_err, 0);
    check("pri_gnt2", alloc_gnt, 1);
    check("pri_addr2", alloc_addr, 2);
    adv();

    vec = 4'b1111; flush = 1'b1;
    @(negedge clk);
    check("fl0_wen", wen, 0);
    check("fl0_gnt", alloc_gnt, 0);
    check("fl0_busy", flush_busy, 0);
    adv();
    flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("fl_busy", flush_busy, 1);
      check("fl_wen", wen, 1);
      check("fl_waddr", waddr, k);
      check("fl_wdata", wdata, 0);
      check("fl_gnt", alloc_gnt, 0);
      adv();
    end
    @(negedge clk);
    check("fl5_empty", empty, 1);
    check("fl5_busy", flush_busy, 0);
    check("fl5_gnt", alloc_gnt, 1);
    check("fl5_addr", alloc_addr, 0);
    adv();

    alloc_req = 1'b0; vec = 4'b0000; free_valid = 1'b1; free_addr = 2'd1;
    @(negedge clk);
    check("ferr_wen", wen, 1);
    check("ferr_waddr", waddr, 1);
    check("ferr_pre", free_err, 0);
    adv();
    free_valid = 1'b0;
    @(negedge clk);
    check("ferr_pulse", free_err, 1);
    adv();
    @(negedge clk);
    check("ferr_clear", free_err, 0);
    adv();

    vec = 4'b1111; flush = 1'b1;
    adv();
    flush = 1'b0;
    @(negedge clk);
    check("mid_busy1", flush_busy, 1);
    adv();
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_wen", wen, 0);
    check("mid_rst_busy", flush_busy, 0);
    adv();
    rst_n = 1'b1; alloc_req = 1'b1;
    @(negedge clk);
    check("mid_vec", vec, 4'b1110);
    check("mid_busy", flush_busy, 0);
    check("mid_gnt", alloc_gnt, 1);
    check("mid_addr", alloc_addr, 0);
    adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
